pc_next_unit: RTL and testbench

Program-counter register and branch-resolution stage of the RV32 core, directly downstream of the branch encoder. It combines the encoded branch kind (BGE/BNE) with the ALU flags to decide whether a branch is taken. It drives the PC-source select and updates the PC register. On every redirect it runs a fixed-length flush sequence that squashes the wrong-path instructions already fetched.

---
 rtl/pc_next_unit.sv | 203 ++++++++++++++++++++
 tb/tb_pc_next_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// pc_next_unit
// ------------
// Program-counter register and branch-resolution stage of the RV32 core.
// Resolves BGE/BNE branches from the ALU flags, selects the next PC source,
// holds the PC register, and runs a fixed-length flush window after every
// redirect so that wrong-path instructions already fetched are squashed.
//
// Optional feature macro: PC_MISALIGN_CHECK_EN
//   defined   : a taken branch to a target with [1:0] != 0 is not followed;
//               o_misaligned is set (sticky until reset) and the FSM halts.
//   undefined : target bits [1:0] are forced to zero on load, o_misaligned
//               is tied to 0 and no HALT state exists.
//
// Parameters:
//   RESET_PC      PC value loaded on reset.
//   FLUSH_CYCLES  cycles o_flush stays high after a redirect (1..7).
//
// Ports:
//   i_clk            core clock, rising edge
//   i_reset          synchronous active-high reset
//   i_stall          hazard stall; freezes PC and flush counter
//   i_branch         decoded instruction is a conditional branch
//   i_encoded_branch branch kind: 0 = BGE, 1 = BNE (may be X if i_branch=0)
//   i_zero           rs1 == rs2
//   i_less           signed rs1 < rs2
//   i_branch_target  branch target address from EX
//   o_pc             registered program counter (fetch address)
//   o_pc_plus4       combinational PC + 4 (modulo 2^32)
//   o_pc_source      combinational; 1 = next PC is the branch target
//   o_flush          registered; squash IF/ID and ID/EX
//   o_misaligned     sticky misaligned-target flag
module pc_next_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_branch,
  input  logic        i_encoded_branch,
  input  logic        i_zero,
  input  logic        i_less,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_pc_source,
  output logic        o_flush,
  output logic        o_misaligned
);

  localparam int unsigned      CNT_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
`ifdef PC_MISALIGN_CHECK_EN
    ST_HALT  = 2'b10,
`endif
    ST_FLUSH = 2'b01
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [31:0]       r_pc;
  logic [31:0]       w_pc_next;
  logic [31:0]       w_pc_plus4;
  logic [31:0]       w_target;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              r_flush;
  logic              w_taken;
  logic              w_run_go;
  logic              w_redirect;
  logic              w_halt_req;

  // Gate on i_branch first so an X branch kind cannot leak into taken.
  assign w_taken    = i_branch ? (i_encoded_branch ? ~i_zero : ~i_less) : 1'b0;
  assign w_run_go   = (r_state == ST_RUN) & ~i_stall & w_taken;
  assign w_pc_plus4 = r_pc + 32'd4;
  // Low bits are always cleared; in the checked build a misaligned target
  // never reaches the load path anyway.
  assign w_target   = i_branch_target & 32'hFFFF_FFFC;

`ifdef PC_MISALIGN_CHECK_EN
  assign w_halt_req = w_run_go & (i_branch_target[1:0] != 2'b00);
`else
  assign w_halt_req = 1'b0;
`endif
  assign w_redirect = w_run_go & ~w_halt_req;

  // State register plus PC, flush counter and registered Flush.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_cnt   <= CNT_ZERO;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_cnt   <= w_cnt_next;
      r_flush <= (w_state_next == ST_FLUSH);
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_halt_req) begin
`ifdef PC_MISALIGN_CHECK_EN
          w_state_next = ST_HALT;
`else
          w_state_next = ST_RUN;
`endif
        end else if (w_redirect) begin
          w_state_next = ST_FLUSH;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Branch inputs belong to squashed instructions and are ignored here.
        if (!i_stall && (r_cnt == CNT_ZERO)) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_FLUSH;
        end
      end
`ifdef PC_MISALIGN_CHECK_EN
      ST_HALT: begin
        w_state_next = ST_HALT;
      end
`endif
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // Datapath outputs: next PC and flush counter.
  always_comb begin
    w_pc_next  = r_pc;
    w_cnt_next = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (i_stall) begin
          w_pc_next = r_pc;
        end else if (w_redirect) begin
          w_pc_next  = w_target;
          w_cnt_next = CNT_LOAD;
        end else if (w_halt_req) begin
          w_pc_next = r_pc;
        end else begin
          w_pc_next = w_pc_plus4;
        end
      end
      ST_FLUSH: begin
        if (i_stall) begin
          w_pc_next = r_pc;
        end else begin
          w_pc_next = w_pc_plus4;
          if (r_cnt != CNT_ZERO) begin
            w_cnt_next = r_cnt - CNT_ONE;
          end else begin
            w_cnt_next = r_cnt;
          end
        end
      end
      default: begin
        w_pc_next = r_pc;
      end
    endcase
  end

`ifdef PC_MISALIGN_CHECK_EN
  logic r_misaligned;

  // Sticky misaligned flag, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_misaligned <= 1'b0;
    end else if (w_halt_req) begin
      r_misaligned <= 1'b1;
    end else begin
      r_misaligned <= r_misaligned;
    end
  end

  assign o_misaligned = r_misaligned;
`else
  assign o_misaligned = 1'b0;
`endif

  assign o_pc        = r_pc;
  assign o_pc_plus4  = w_pc_plus4;
  assign o_pc_source = w_redirect;
  assign o_flush     = r_flush;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit (RESET_PC=0x100, FLUSH_CYCLES=2).
// Expected values are pushed onto a scoreboard queue when a step is driven
// and popped when the DUT output is sampled.
module tb_pc_next_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_stall;
  logic        i_branch;
  logic        i_encoded_branch;
  logic        i_zero;
  logic        i_less;
  logic [31:0] i_branch_target;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic        o_pc_source;
  logic        o_flush;
  logic        o_misaligned;

  pc_next_unit #(
    .RESET_PC     (RST_PC),
    .FLUSH_CYCLES (2)
  ) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_stall          (i_stall),
    .i_branch         (i_branch),
    .i_encoded_branch (i_encoded_branch),
    .i_zero           (i_zero),
    .i_less           (i_less),
    .i_branch_target  (i_branch_target),
    .o_pc             (o_pc),
    .o_pc_plus4       (o_pc_plus4),
    .o_pc_source      (o_pc_source),
    .o_flush          (o_flush),
    .o_misaligned     (o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] cur_pc;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Drive one cycle at the falling edge, check combinational outputs before
  // the rising edge and registered outputs at the next falling edge.
  task automatic step(input string name, input logic rst, input logic st,
                      input logic br, input logic enc, input logic z,
                      input logic l, input logic [31:0] tgt,
                      input logic e_src, input logic [31:0] e_pc,
                      input logic e_fl, input logic e_mis);
    i_reset          = rst;
    i_stall          = st;
    i_branch         = br;
    i_encoded_branch = enc;
    i_zero           = z;
    i_less           = l;
    i_branch_target  = tgt;
    push({name, ":pc_source"}, {31'd0, e_src});
    push({name, ":pc_plus4"}, cur_pc + 32'd4);
    #1;
    pop_chk({31'd0, o_pc_source});
    pop_chk(o_pc_plus4);
    push({name, ":pc"}, e_pc);
    push({name, ":flush"}, {31'd0, e_fl});
    push({name, ":misaligned"}, {31'd0, e_mis});
    @(posedge i_clk);
    @(negedge i_clk);
    pop_chk(o_pc);
    pop_chk({31'd0, o_flush});
    pop_chk({31'd0, o_misaligned});
    cur_pc = e_pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    i_reset          = 1'b1;
    i_stall          = 1'b0;
    i_branch         = 1'b0;
    i_encoded_branch = 1'b0;
    i_zero           = 1'b0;
    i_less           = 1'b0;
    i_branch_target  = 32'd0;
    @(posedge i_clk);
    @(negedge i_clk);
    cur_pc = RST_PC;
    push("reset:pc", RST_PC);
    push("reset:pc_plus4", RST_PC + 32'd4);
    push("reset:pc_source", 32'd0);
    push("reset:flush", 32'd0);
    push("reset:misaligned", 32'd0);
    pop_chk(o_pc);
    pop_chk(o_pc_plus4);
    pop_chk({31'd0, o_pc_source});
    pop_chk({31'd0, o_flush});
    pop_chk({31'd0, o_misaligned});

    // name, rst, stall, br, enc, z, l, target, src, pc_after, flush, mis
    step("seq0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, 1'b0);
    step("seq1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h108, 1'b0, 1'b0);
    step("seq2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h10C, 1'b0, 1'b0);
    // BNE taken -> two flush cycles
    step("bne_tk", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 1'b0);
    step("fl1",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h204, 1'b1, 1'b0);
    step("fl_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h208, 1'b0, 1'b0);
    // not-taken cases
    step("bge_nt", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h700, 1'b0, 32'h20C, 1'b0, 1'b0);
    step("bne_nt", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h700, 1'b0, 32'h210, 1'b0, 1'b0);
    step("enc_x",  1'b0, 1'b0, 1'b0, 1'bx, 1'b0, 1'b0, 32'h700, 1'b0, 32'h214, 1'b0, 1'b0);
    // stall beats taken, then redirect once released
    step("st_tk",  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 1'b0, 32'h214, 1'b0, 1'b0);
    step("rel_tk", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 1'b1, 32'h300, 1'b1, 1'b0);
    // stall inside flush stretches the window; taken in FLUSH is ignored
    step("fl_st",  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 1'b0, 32'h300, 1'b1, 1'b0);
    step("fl_ign", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 1'b0, 32'h304, 1'b1, 1'b0);
    step("fl_ex",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h308, 1'b0, 1'b0);
    // BGE taken then reset mid-flush
    step("bge_tk", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h500, 1'b1, 32'h500, 1'b1, 1'b0);
    step("rst_fl", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, RST_PC,  1'b0, 1'b0);
    step("post_r", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 1'b0);
    // PC + 4 wraps modulo 2^32
    step("to_top", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    step("wrap",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    step("wrap2",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_0004, 1'b0, 1'b0);
`ifdef PC_MISALIGN_CHECK_EN
    step("mis_tk", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h202, 1'b0, 32'h4, 1'b0, 1'b1);
    step("halt1",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h4, 1'b0, 1'b1);
    step("halt_b", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 1'b0, 32'h4, 1'b0, 1'b1);
    step("rst_h",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, RST_PC, 1'b0, 1'b0);
`else
    step("mis_tk", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h202, 1'b1, 32'h200, 1'b1, 1'b0);
    step("mis_f1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h204, 1'b1, 1'b0);
    step("mis_f2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h208, 1'b0, 1'b0);
    step("rst_m",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, RST_PC, 1'b0, 1'b0);
`endif
    step("final",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
